// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants and address-match helper for the MMIO hub
package mmio_pkg;

  localparam int          MMIO_DATA_W   = 32;
  localparam logic [31:0] CTRL_PEND_OFS = 32'h0;
  localparam logic [31:0] CTRL_MASK_OFS = 32'h4;

  // Exact-match decode only: misaligned or in-between addresses never hit.
  function automatic logic port_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] stride,
                                    input int          k);
    return addr == (base + 32'(k) * stride);
  endfunction

endpackage

// File: rtl/irq_edge_ctrl.sv
// rtl/irq_edge_ctrl.sv - rising-edge interrupt latch with W1C pending, mask and registered INTR
module irq_edge_ctrl #(
  parameter int N_IRQ = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_IRQ-1:0] IRQ_SRC,
  input  logic             clr_wr,
  input  logic [N_IRQ-1:0] clr_data,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_data,
  output logic [N_IRQ-1:0] pend_o,
  output logic [N_IRQ-1:0] mask_o,
  output logic             intr_o
);

  logic [N_IRQ-1:0] prev_q, pend_q, mask_q;
  logic [N_IRQ-1:0] pend_d, mask_d;
  logic             intr_q;

  // A new edge is OR-ed in after the clear so that set beats clear.
  always_comb begin
    pend_d = pend_q;
    if (clr_wr) pend_d = pend_d & ~clr_data;
    pend_d = pend_d | (IRQ_SRC & ~prev_q);
    mask_d = mask_wr ? mask_data : mask_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      intr_q <= 1'b0;
    end else begin
      prev_q <= IRQ_SRC;
      pend_q <= pend_d;
      mask_q <= mask_d;
      intr_q <= |(pend_q & mask_q);
    end
  end

  assign pend_o = pend_q;
  assign mask_o = mask_q;
  assign intr_o = intr_q;

endmodule

// File: rtl/mmio_io_hub.sv
// rtl/mmio_io_hub.sv - indexed MMIO port banks with write strobes and interrupt aggregation
module mmio_io_hub
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h11000000,
  parameter logic [31:0] STRIDE    = 32'h20,
  parameter int          N_OUT     = 8,
  parameter int          N_IN      = 8,
  parameter int          N_IRQ     = 4,
  parameter logic [31:0] CTRL_OFS  = 32'h400
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            IOBUS_ADDR,
  input  logic [31:0]            IOBUS_OUT,
  input  logic                   IOBUS_WR,
  output logic [31:0]            IOBUS_IN,
  output logic [N_OUT*32-1:0]    OUT_DATA,
  output logic [N_OUT-1:0]       OUT_STB,
  input  logic [N_IN*32-1:0]     IN_DATA,
  input  logic [N_IRQ-1:0]       IRQ_SRC,
  output logic                   INTR
);

  localparam int          N_MAX     = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam logic [31:0] PEND_ADDR = BASE_ADDR + CTRL_OFS + CTRL_PEND_OFS;
  localparam logic [31:0] MASK_ADDR = BASE_ADDR + CTRL_OFS + CTRL_MASK_OFS;

  if (32'(N_MAX) * STRIDE > CTRL_OFS) begin : g_ctrl_overlap
    $error("mmio_io_hub: port banks overlap the control block");
  end

  logic [N_OUT*32-1:0] out_q, out_d;
  logic [N_OUT-1:0]    stb_q, stb_d;
  logic [N_IRQ-1:0]    pend, mask;
  logic [31:0]         rd_data;
  logic                clr_wr, mask_wr;

  assign clr_wr  = IOBUS_WR && (IOBUS_ADDR == PEND_ADDR);
  assign mask_wr = IOBUS_WR && (IOBUS_ADDR == MASK_ADDR);

  always_comb begin
    out_d = out_q;
    stb_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (IOBUS_WR && port_hit(IOBUS_ADDR, BASE_ADDR, STRIDE, k)) begin
        out_d[k*MMIO_DATA_W +: MMIO_DATA_W] = IOBUS_OUT;
        stb_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q <= '0;
      stb_q <= '0;
    end else begin
      out_q <= out_d;
      stb_q <= stb_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (port_hit(IOBUS_ADDR, BASE_ADDR, STRIDE, k))
        rd_data = IN_DATA[k*MMIO_DATA_W +: MMIO_DATA_W];
    end
    if (IOBUS_ADDR == PEND_ADDR) rd_data = MMIO_DATA_W'(pend);
    if (IOBUS_ADDR == MASK_ADDR) rd_data = MMIO_DATA_W'(mask);
  end

  irq_edge_ctrl #(.N_IRQ(N_IRQ)) u_irq (
    .CLK      (CLK),
    .RST      (RST),
    .IRQ_SRC  (IRQ_SRC),
    .clr_wr   (clr_wr),
    .clr_data (IOBUS_OUT[N_IRQ-1:0]),
    .mask_wr  (mask_wr),
    .mask_data(IOBUS_OUT[N_IRQ-1:0]),
    .pend_o   (pend),
    .mask_o   (mask),
    .intr_o   (INTR)
  );

  assign IOBUS_IN = rd_data;
  assign OUT_DATA = out_q;
  assign OUT_STB  = stb_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// tb/tb_mmio_io_hub.sv - self-checking bench for mmio_io_hub
module tb_mmio_io_hub;

  localparam logic [31:0] BASE  = 32'h11000000;
  localparam logic [31:0] STR   = 32'h20;
  localparam int          NO    = 8;
  localparam int          NI    = 8;
  localparam int          NQ    = 4;
  localparam logic [31:0] PENDA = 32'h11000400;
  localparam logic [31:0] MASKA = 32'h11000404;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     addr, wdata, rdata;
  logic            wr;
  logic [NO*32-1:0] out_data;
  logic [NO-1:0]   out_stb;
  logic [NI*32-1:0] in_data;
  logic [NQ-1:0]   src;
  logic            intr;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_out [NO];
  logic [31:0] m_in  [NI];
  logic [NO-1:0] m_stb;
  logic [NQ-1:0] m_pend, m_mask, m_prev;
  logic          m_intr;
  bit            m_valid = 0;

  always #5 clk = ~clk;

  mmio_io_hub dut (
    .CLK(clk), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
    .IOBUS_IN(rdata), .OUT_DATA(out_data), .OUT_STB(out_stb), .IN_DATA(in_data),
    .IRQ_SRC(src), .INTR(intr)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Port index from address arithmetic; -1 when the address is not a port slot.
  function automatic int slot_of(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return -1;
    off = a - BASE;
    if (off % STR != 0) return -1;
    if (off / STR > 32'd1000) return -1;
    return int'(off / STR);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int s;
    if (a == PENDA) return 32'(m_pend);
    if (a == MASKA) return 32'(m_mask);
    s = slot_of(a);
    if (s >= 0 && s < NI) return m_in[s];
    return 32'h0;
  endfunction

  function automatic logic [NO*32-1:0] model_out_vec();
    logic [NO*32-1:0] v;
    for (int k = 0; k < NO; k++) v[k*32 +: 32] = m_out[k];
    return v;
  endfunction

  always @(posedge clk) begin
    logic [NQ-1:0] np;
    int s;
    if (rst) begin
      for (int k = 0; k < NO; k++) m_out[k] = '0;
      m_stb = '0; m_pend = '0; m_mask = '0; m_prev = '0; m_intr = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      m_stb = '0;
      s = slot_of(addr);
      if (wr && s >= 0 && s < NO) begin
        m_out[s] = wdata;
        m_stb[s] = 1'b1;
      end
      np = m_pend;
      if (wr && addr == PENDA) np = np & ~wdata[NQ-1:0];
      np = np | (src & ~m_prev);
      m_intr = |(m_pend & m_mask);
      if (wr && addr == MASKA) m_mask = wdata[NQ-1:0];
      m_prev = src;
      m_pend = np;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_out_data", out_data, model_out_vec());
      check("model_out_stb", out_stb, m_stb);
      check("model_intr", intr, m_intr);
      check("model_iobus_in", rdata, model_read(addr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; addr = '0; wdata = '0; src = '0;
    for (int k = 0; k < NI; k++) m_in[k] = 32'hA000_0000 | 32'(k);
    m_in[3] = 32'h1234;
    for (int k = 0; k < NI; k++) in_data[k*32 +: 32] = m_in[k];

    cyc(); cyc();
    rst = 1'b0; addr = MASKA;
    @(negedge clk);
    check("rst_out_data", out_data, '0);
    check("rst_out_stb", out_stb, '0);
    check("rst_intr", intr, 1'b0);
    check("rst_mask_read", rdata, 32'h0);

    addr = 32'h11000020; wdata = 32'h0000BEEF; wr = 1'b1;
    cyc(); wr = 1'b0;
    @(negedge clk);
    check("wr_port1_data", out_data[63:32], 32'hBEEF);
    check("wr_port1_stb", out_stb, 8'b0000_0010);
    cyc();
    @(negedge clk);
    check("stb_one_cycle", out_stb, 8'b0);

    addr = 32'h11000024; wdata = 32'hFFFF_FFFF; wr = 1'b1;
    cyc(); wr = 1'b0;
    @(negedge clk);
    check("misaligned_data", out_data[63:32], 32'hBEEF);
    check("misaligned_stb", out_stb, 8'b0);

    addr = 32'h11000060; #1;
    check("read_port3", rdata, 32'h1234);
    addr = 32'h11000100; #1;
    check("read_k8_zero", rdata, 32'h0);

    addr = 32'h11000000; wdata = 32'h1; wr = 1'b1; cyc();
    addr = 32'h11000020; wdata = 32'h2; cyc();
    wr = 1'b0;
    @(negedge clk);
    check("b2b_stb_second", out_stb, 8'b0000_0010);
    check("b2b_port0", out_data[31:0], 32'h1);

    addr = MASKA; wdata = 32'hFFFF_FFF5; wr = 1'b1;
    cyc(); wr = 1'b0;
    @(negedge clk);
    check("mask_read", rdata, 32'h5);
    src = 4'b0100; addr = PENDA;
    cyc();
    @(negedge clk);
    check("pend_after_edge", rdata, 32'h4);
    check("intr_not_yet", intr, 1'b0);
    cyc();
    @(negedge clk);
    check("intr_set", intr, 1'b1);
    wdata = 32'h4; wr = 1'b1;
    cyc(); wr = 1'b0;
    @(negedge clk);
    check("pend_cleared", rdata, 32'h0);
    check("intr_lag", intr, 1'b1);
    cyc();
    @(negedge clk);
    check("intr_cleared", intr, 1'b0);

    src = 4'b0101; wdata = 32'h1; wr = 1'b1;
    cyc(); wr = 1'b0;
    @(negedge clk);
    check("set_beats_clear", rdata, 32'h1);
    wdata = 32'h1; wr = 1'b1;
    cyc(); wr = 1'b0;

    src = 4'b0111;
    for (int i = 0; i < 10; i++) cyc();
    @(negedge clk);
    check("held_pend", rdata, 32'h2);
    wdata = 32'h2; wr = 1'b1;
    cyc(); wr = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk);
    check("held_once", rdata, 32'h0);

    rst = 1'b1; src = 4'b0001; addr = 32'h11000000; wdata = 32'hDEAD; wr = 1'b1;
    cyc();
    rst = 1'b0; wr = 1'b0; addr = PENDA;
    @(negedge clk);
    check("rst_wins_data", out_data[31:0], 32'h0);
    check("rst_wins_stb", out_stb, 8'b0);
    check("pend_in_reset", rdata, 32'h0);
    cyc();
    @(negedge clk);
    check("pend_after_release", rdata, 32'h1);

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_io_hub.md
Name: mmio_io_hub

Overview:
Parametrised memory-mapped I/O hub between the Otter_MCU IOBUS and board peripherals.
- Replaces hand-written per-address case decode with indexed banks of input ports and output registers.
- Output writes generate one-cycle write strobes (e.g. framebuffer WE).
- Adds an edge-triggered, maskable interrupt aggregator that drives the CPU INTR pin.

Parameters:
- BASE_ADDR, 32'h11000000, address of port 0.
- STRIDE, 32'h20, byte spacing between consecutive ports.
- N_OUT, 8, number of 32-bit output registers (1..32).
- N_IN, 8, number of 32-bit input ports (1..32).
- N_IRQ, 4, number of interrupt sources (1..32).
- CTRL_OFS, 32'h400, offset of the control block from BASE_ADDR. IRQ_PEND is at +0x0, IRQ_MASK at +0x4.

Ports:
- CLK  in  1  system clock (CPU clock domain).
- RST  in  1  synchronous active-high reset.
- IOBUS_ADDR  in  32  CPU bus address.
- IOBUS_OUT  in  32  CPU write data.
- IOBUS_WR  in  1  CPU write enable.
- IOBUS_IN  out  32  read data to CPU.
- OUT_DATA  out  N_OUT*32  output registers; port k occupies bits [32k+31:32k].
- OUT_STB  out  N_OUT  one-cycle write strobe per output port.
- IN_DATA  in  N_IN*32  input ports, same packing as OUT_DATA.
- IRQ_SRC  in  N_IRQ  interrupt sources, synchronous to CLK, level.
- INTR  out  1  interrupt request to CPU.

Behaviour:
Clock and reset:
- One clock, CLK. Reset RST is synchronous and active-high.
- Reset values: OUT_DATA=0, OUT_STB=0, pend=0, mask=0, irq_prev=0, INTR=0.
- RST has priority over any write in the same cycle.

Address decode:
- Port k hit when IOBUS_ADDR == BASE_ADDR + k*STRIDE.
- Only exact matches hit; misaligned addresses and addresses between ports never hit.
- The same index k selects input port k on reads and output register k on writes.

Write path:
- On a CLK edge with IOBUS_WR=1 and a hit on k<N_OUT: OUT_DATA[k] <= IOBUS_OUT, visible the next cycle.
- In that same cycle OUT_STB[k] is 1 for exactly one cycle. Back-to-back writes produce back-to-back strobes.
- Writes to k>=N_OUT or to unmapped addresses are ignored.

Read path:
- Combinational, zero latency.
- IOBUS_IN = IN_DATA[k] on a hit with k<N_IN.
- IOBUS_IN = {0, pend} at IRQ_PEND; {0, mask} at IRQ_MASK.
- IOBUS_IN = 0 otherwise.

Interrupt controller:
- irq_prev <= IRQ_SRC every cycle.
- Rising edge (IRQ_SRC[i] & ~irq_prev[i]) sets pend[i] on the next edge.
- Because irq_prev resets to 0, a source held high through reset release sets pend on the first cycle after reset.
- A source held high sets pend only once.
- Write to IRQ_PEND is write-1-to-clear. Writing 1 to bit i clears pend[i]; writing 0 has no effect.
- Simultaneous rising edge and clear on the same bit: set wins, so pend stays 1.
- Write to IRQ_MASK loads mask <= IOBUS_OUT[N_IRQ-1:0].
- INTR <= |(pend & mask), registered, so it rises one cycle after pend or mask changes.
- INTR is level-held until software clears pend or masks the source.
- Upper bits of control writes are ignored; upper bits of control reads return 0.

Boundary conditions:
- N_IN != N_OUT is legal; each bank decodes independently.
- BASE_ADDR + CTRL_OFS must not overlap any port address. Elaboration fails via an assertion if max(N_IN,N_OUT)*STRIDE > CTRL_OFS.

Decomposition:
- Package mmio_pkg holds:
  - CTRL_PEND_OFS = 0 and CTRL_MASK_OFS = 4;
  - the MMIO_DATA_W = 32 constant;
  - a function port_hit(addr, base, stride, k) returning the exact-match decision.
- Sub-module irq_edge_ctrl (parameter N_IRQ) holds irq_prev, pend, mask and the INTR register. Its inputs are IRQ_SRC, clr_wr, clr_data, mask_wr and mask_data.

Test Plan:
- Reset with RST=1 for 2 cycles -> OUT_DATA=0, OUT_STB=0, INTR=0; read of IRQ_MASK at 0x11000404 returns 0.
- Write 0x0000BEEF to 0x11000020 -> next cycle OUT_DATA[1]=0xBEEF and OUT_STB=8'b0000_0010 for one cycle only. Writing 0x11000024 (misaligned) changes nothing.
- IN_DATA[3]=0x1234 with IOBUS_ADDR=0x11000060 -> IOBUS_IN=0x1234 in the same cycle. Address 0x11000100 (k=8>=N_IN) -> 0.
- Mask=4'b0101, rising edge on IRQ_SRC[2]:
  - pend=4'b0100 the next cycle and INTR=1 one cycle later;
  - then W1C write 0x4 to 0x11000400 -> pend=0 and INTR=0 one cycle later.
- Same-cycle rising edge on IRQ_SRC[0] and W1C of bit 0 -> pend[0] remains 1. IRQ_SRC[1] held high for 10 cycles -> pend[1] set once, and stays 0 after a single clear.
- RST asserted in the same cycle as a write to port 0 with IRQ_SRC=4'b0001 held -> OUT_DATA[0]=0 and no strobe; pend[0]=1 on the first cycle after reset deassertion.
